ahb2apb_bridge: RTL

AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

---
 rtl/ahb_apb_pkg.sv | 26 ++
 rtl/ahb2apb_strb_gen.sv | 24 ++
 rtl/ahb2apb_bridge.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and encodings for the AHB-Lite to APB4 bridge:
// FSM states, HTRANS/HRESP codes and HSIZE values.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/ahb2apb_strb_gen.sv
// Byte-lane write strobe for a 32-bit APB4 bus from the
// transfer direction, size and low address bits.
module ahb2apb_strb_gen
    import ahb_apb_pkg::*;
(
    input  logic       write,
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb
);

    always_comb begin
        strb = 4'b0000;
        if (write) begin
            case (size)
                HSIZE_BYTE: strb = 4'b0001 << addr_lo;
                HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
                HSIZE_WORD: strb = 4'b1111;
                default:    strb = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB4 bridge: one APB access per AHB beat,
// with a two-cycle AHB ERROR response on PSLVERR.
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTERLOCK,
    input  logic                  HREADYIN,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic [2:0]              pprot_q;
    logic [DATA_WIDTH-1:0]   hrdata_q;
    logic                    can_accept;
    logic                    accept;
    logic                    complete;
    logic                    unused;

    // Burst and lock carry no meaning on APB; each beat stands alone.
    assign unused = ^{HBURST, HMASTERLOCK, HPROT[3:2], HTRANS[0]};

    assign can_accept = (state_q == ST_IDLE) ||
                        (state_q == ST_DONE) ||
                        (state_q == ST_ERR2);
    assign accept     = can_accept && HSEL && HREADYIN && HTRANS[1];
    assign complete   = (state_q == ST_ACCESS) && PREADY;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                state_d = accept ? ST_SETUP : ST_IDLE;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? ST_ERR1 : ST_DONE;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state_q)
            ST_SETUP: begin
                PSEL      = 1'b1;
                HREADYOUT = 1'b0;
            end
            ST_ACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                HREADYOUT = 1'b0;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP     = HRESP_ERROR;
            end
            default: begin
            end
        endcase
    end

    // PPROT is stored already mapped so that reset yields all zeros.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            pprot_q  <= 3'd0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
                pprot_q <= {~HPROT[0], 1'b0, HPROT[1]};
            end
            if (complete && !write_q) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    ahb2apb_strb_gen u_strb_gen (
        .write   (write_q),
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .strb    (PSTRB)
    );

    // HWDATA is held by the master while HREADYOUT is low.
    assign PWDATA = PSEL ? HWDATA : '0;
    assign PADDR  = addr_q;
    assign PWRITE = write_q;
    assign PPROT  = pprot_q;
    assign HRDATA = hrdata_q;

endmodule
